timer_counter: RTL and testbench

- Memory-mapped countdown timer. Sits on the bridge side of the CPU and drives one bit of the hardware interrupt vector consumed by the coprocessor-0 exception unit.
- Software programs a preload value and a control word with sw and reads state back with lw.
- On expiry it raises an interrupt request, either held (one-shot) or a single-cycle pulse (auto-reload).

---
 rtl/timer_counter.sv | 126 ++++++++++++
 tb/tb_timer_counter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// It drives one interrupt request line into the CP0 hardware interrupt vector.
module timer_counter #(
    parameter logic [31:0] PRESET_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic ctrl_wr;
    logic preset_wr;
    logic reload;
    logic load_cnt;
    logic dec_cnt;
    logic zero_cnt;
    logic clr_en;
    logic set_flag;

    assign ctrl_wr   = we && (addr == ADDR_CTRL);
    assign preset_wr = we && (addr == ADDR_PRESET);
    // MODE 1x falls back to one-shot
    assign reload    = (ctrl_mode == 2'b01);

    always_comb begin
        state_nx = state;
        load_cnt = 1'b0;
        dec_cnt  = 1'b0;
        zero_cnt = 1'b0;
        clr_en   = 1'b0;
        set_flag = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_en) state_nx = LOAD;
            end
            LOAD: begin
                load_cnt = 1'b1;
                state_nx = CNT;
            end
            CNT: begin
                if (!ctrl_en) begin
                    state_nx = IDLE;
                end else if (count > 32'd1) begin
                    dec_cnt = 1'b1;
                end else begin
                    zero_cnt = 1'b1;
                    set_flag = !reload;
                    state_nx = INT;
                end
            end
            INT: begin
                if (reload) begin
                    state_nx = LOAD;
                end else begin
                    clr_en   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
            preset    <= PRESET_INIT;
            count     <= 32'd0;
            irq_flag  <= 1'b0;
        end else begin
            state <= state_nx;
            if (preset_wr) preset <= wdata;
            // A software CTRL write overrides the one-shot EN auto-clear
            if (ctrl_wr) begin
                ctrl_en   <= wdata[0];
                ctrl_mode <= wdata[2:1];
                ctrl_im   <= wdata[3];
            end else if (clr_en) begin
                ctrl_en <= 1'b0;
            end
            if (load_cnt)      count <= preset;
            else if (dec_cnt)  count <= count - 32'd1;
            else if (zero_cnt) count <= 32'd0;
            if (set_flag)      irq_flag <= 1'b1;
            else if (ctrl_wr)  irq_flag <= 1'b0;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_CTRL:   rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
            ADDR_PRESET: rdata = preset;
            ADDR_COUNT:  rdata = count;
            default:     rdata = 32'd0;
        endcase
    end

    assign irq = ctrl_im & (irq_flag | ((state == INT) & reload));

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register access, one-shot, auto-reload,
// masking, mid-count disable, reset abort and boundary cases.
module tb_timer_counter;

    localparam logic [31:0] INIT = 32'h0000_1234;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks;
    int failures;

    timer_counter #(.PRESET_INIT(INIT)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write lands on the next rising edge; returns 1 time unit after it.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        logic        seen;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        we       = 1'b0;
        addr     = 2'd0;
        wdata    = 32'd0;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        rd(2'd0, v); chk("rst_ctrl", v, 32'd0);
        rd(2'd1, v); chk("rst_preset", v, INIT);
        rd(2'd2, v); chk("rst_count", v, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // reset mid-count
        wr(2'd1, 32'd5);
        rd(2'd1, v); chk("preset_rb", v, 32'd5);
        wr(2'd0, 32'h9);
        tick(3);
        rd(2'd2, v); chk("mid_count", v, 32'd4);
        reset = 1'b0;
        #1;
        rd(2'd2, v); chk("async_count", v, 32'd0);
        rd(2'd0, v); chk("async_ctrl", v, 32'd0);
        rd(2'd1, v); chk("async_preset", v, INIT);
        chk("async_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            seen = seen | irq;
        end
        chk("post_rst_noirq", {31'd0, seen}, 32'd0);

        // one-shot, PRESET=3
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick(4);
        chk("os_irq_e4", {31'd0, irq}, 32'd0);
        tick(1);
        chk("os_irq_e5", {31'd0, irq}, 32'd1);
        rd(2'd2, v); chk("os_count_e5", v, 32'd0);
        tick(1);
        rd(2'd0, v); chk("os_ctrl_en_clr", v, 32'h8);
        tick(3);
        chk("os_irq_held", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'd0);
        chk("os_irq_cleared", {31'd0, irq}, 32'd0);

        // auto-reload, PRESET=2: pulses at edges 4,8,12; count 2,1,0,0
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int e = 1; e <= 12; e++) begin
            logic [31:0] ec;
            tick(1);
            ec = ((e % 4) == 2) ? 32'd2 : (((e % 4) == 3) ? 32'd1 : 32'd0);
            chk($sformatf("ar_irq_e%0d", e), {31'd0, irq}, {31'd0, (e % 4) == 0});
            rd(2'd2, v);
            chk($sformatf("ar_count_e%0d", e), v, ec);
        end
        wr(2'd0, 32'd0);
        tick(3);

        // masked one-shot, PRESET=4
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            seen = seen | irq;
        end
        chk("mask_noirq", {31'd0, seen}, 32'd0);
        rd(2'd2, v); chk("mask_count", v, 32'd0);
        rd(2'd0, v); chk("mask_en_clr", v, 32'd0);

        // disable at COUNT=2 with IM set
        wr(2'd0, 32'h9);
        tick(3);
        wr(2'd0, 32'h8);
        rd(2'd2, v); chk("dis_count_e4", v, 32'd2);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            seen = seen | irq;
        end
        rd(2'd2, v); chk("dis_count_hold", v, 32'd2);
        chk("dis_noirq", {31'd0, seen}, 32'd0);

        // PRESET=0 one-shot
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick(2);
        chk("p0_irq_e2", {31'd0, irq}, 32'd0);
        tick(1);
        chk("p0_irq_e3", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'd0);
        tick(2);

        // PRESET all ones
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, v); chk("pmax_rb", v, 32'hFFFF_FFFF);
        wr(2'd0, 32'h1);
        tick(2);
        rd(2'd2, v); chk("pmax_load", v, 32'hFFFF_FFFF);
        tick(1);
        rd(2'd2, v); chk("pmax_dec", v, 32'hFFFF_FFFE);
        wr(2'd0, 32'd0);
        tick(2);
        rd(2'd2, v); chk("pmax_hold", v, 32'hFFFF_FFFD);

        // writes to COUNT and reserved address are ignored
        wr(2'd2, 32'h55);
        rd(2'd2, v); chk("count_ro", v, 32'hFFFF_FFFD);
        wr(2'd3, 32'hDEAD_BEEF);
        rd(2'd3, v); chk("rsv_read0", v, 32'd0);
        rd(2'd1, v); chk("rsv_preset", v, 32'hFFFF_FFFF);
        rd(2'd0, v); chk("rsv_ctrl", v, 32'd0);
        rd(2'd0, v); chk("ctrl_upper0", v & 32'hFFFF_FFF0, 32'd0);

        // CTRL write on the CNT->INT edge: flag set still wins
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick(4);
        wr(2'd0, 32'h8);
        chk("tie_irq_e5", {31'd0, irq}, 32'd1);
        tick(2);
        chk("tie_irq_held", {31'd0, irq}, 32'd1);
        rd(2'd0, v); chk("tie_ctrl", v, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
